// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the fetch FSM state encoding, the NOP word returned on errored
// fetches, the runtime patch-slot record and the default ROM image.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP = '0;

  // Widest patch value a slot can carry; narrower builds use the low bits.
  localparam int unsigned PATCH_W_MAX = 16;

  typedef struct packed {
    logic                   valid;
    logic [31:0]            addr;
    logic [PATCH_W_MAX-1:0] val;
  } patch_slot_t;

  // Default ROM image: a simple ramp so every word is distinct and easy to
  // recognise (word 3 is 32'h2001_00A5).
  function automatic logic [31:0] rom_default_word(input int unsigned idx);
    return 32'h2001_00A2 + 32'(idx);
  endfunction

endpackage

// File: rtl/imem_rom.sv
// Synchronous single-port instruction ROM with one-cycle read latency.
// Contents come from the package default image; no control logic lives here.
module imem_rom
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AW-1:0]     addr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] image [DEPTH];

  // Constant ROM image, elaborated from the package default function
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      image[i] = DATA_W'(rom_default_word(i));
    end
  end

  // Registered read port, updated only when a fetch is accepted
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= image[addr];
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: accepts byte-addressed fetch requests,
// reads the ROM, flags misaligned/out-of-range fetches (returned as NOP)
// and optionally substitutes the low bits of matching fetches from a
// runtime patch table. Define IMEM_PATCH_EN to build the patch table;
// without it the patch_* inputs are ignored.
module instr_fetch_ctrl
  import imem_pkg::*;
#(
  parameter  int unsigned DATA_W      = 32,
  parameter  int unsigned DEPTH       = 32,
  parameter  int unsigned PATCH_SLOTS = 4,
  parameter  int unsigned PATCH_W     = 4,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned IDX_W       = (PATCH_SLOTS > 1) ? $clog2(PATCH_SLOTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic [31:0]        fetch_addr,
  output logic               fetch_gnt,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [DATA_W-1:0]  instr_data,
  output logic               instr_err,
  input  logic               patch_we,
  input  logic [IDX_W-1:0]   patch_idx,
  input  logic               patch_en,
  input  logic [31:0]        patch_addr,
  input  logic [PATCH_W-1:0] patch_val
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic              accept;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] rom_data;
  logic              addr_err;
  logic              hit;
  logic [PATCH_W-1:0] hit_val;
  logic [DATA_W-1:0] fetch_word;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_req) state_next = READ;
      READ:    state_next = HOLD;
      HOLD:    if (instr_ready) state_next = fetch_req ? READ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: grant while idle or while the held word is being consumed
  always_comb begin
    fetch_gnt = (state == IDLE) || ((state == HOLD) && instr_ready);
    accept    = fetch_req && fetch_gnt;
  end

  // Latch the byte address of each accepted fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (accept) begin
      addr_q <= fetch_addr;
    end
  end

  imem_rom #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_rom (
    .clk   (clk),
    .en    (accept),
    .addr  (fetch_addr[AW+1:2]),
    .rdata (rom_data)
  );

  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);

`ifdef IMEM_PATCH_EN
  patch_slot_t                slots [PATCH_SLOTS];
  logic [PATCH_W_MAX-1:0]     hit_val_full;
  logic                       unused_val_bits;

  // Patch table writes; an index past the last slot matches no slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PATCH_SLOTS; i++) begin
        slots[i] <= '0;
      end
    end else if (patch_we) begin
      for (int unsigned i = 0; i < PATCH_SLOTS; i++) begin
        if (patch_idx == IDX_W'(i)) begin
          slots[i].valid <= patch_en;
          slots[i].addr  <= patch_addr;
          slots[i].val   <= PATCH_W_MAX'(patch_val);
        end
      end
    end
  end

  // Match the latched address against valid slots; lowest index wins
  always_comb begin
    hit          = 1'b0;
    hit_val_full = '0;
    for (int unsigned i = 0; i < PATCH_SLOTS; i++) begin
      if (!hit && slots[i].valid && (slots[i].addr == addr_q)) begin
        hit          = 1'b1;
        hit_val_full = slots[i].val;
      end
    end
  end

  assign hit_val         = hit_val_full[PATCH_W-1:0];
  assign unused_val_bits = ^hit_val_full;
`else
  logic unused_patch;

  assign unused_patch = ^{patch_we, patch_idx, patch_en, patch_addr, patch_val};
  assign hit          = 1'b0;
  assign hit_val      = '0;
`endif

  // Word presented to the consumer: ROM data, optional patch, NOP on error
  always_comb begin
    fetch_word = rom_data;
    if (hit) begin
      fetch_word[PATCH_W-1:0] = hit_val;
    end
    if (addr_err) begin
      fetch_word = DATA_W'(NOP);
    end
  end

  // Output registers: load in READ, hold in HOLD until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_err   <= 1'b0;
    end else begin
      case (state)
        READ: begin
          instr_valid <= 1'b1;
          instr_data  <= fetch_word;
          instr_err   <= addr_err;
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl. Expected words are
// queued when a fetch is driven and compared when instr_valid rises.
module tb_instr_fetch_ctrl;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned DEPTH       = 32;
  localparam int unsigned PATCH_SLOTS = 3;
  localparam int unsigned PATCH_W     = 4;
  localparam int unsigned IDX_W       = 2;

`ifdef IMEM_PATCH_EN
  localparam bit PATCH_ON = 1'b1;
`else
  localparam bit PATCH_ON = 1'b0;
`endif

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               fetch_req;
  logic [31:0]        fetch_addr;
  logic               fetch_gnt;
  logic               instr_valid;
  logic               instr_ready;
  logic [DATA_W-1:0]  instr_data;
  logic               instr_err;
  logic               patch_we;
  logic [IDX_W-1:0]   patch_idx;
  logic               patch_en;
  logic [31:0]        patch_addr;
  logic [PATCH_W-1:0] patch_val;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  instr_fetch_ctrl #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .PATCH_SLOTS (PATCH_SLOTS),
    .PATCH_W     (PATCH_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_err   (instr_err),
    .patch_we    (patch_we),
    .patch_idx   (patch_idx),
    .patch_en    (patch_en),
    .patch_addr  (patch_addr),
    .patch_val   (patch_val)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=output expected=no_pending_entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "/data"}, instr_data, e.data);
      check({tag, "/err"}, 32'(instr_err), 32'(e.err));
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] a,
                       input logic [31:0] ed, input logic ee);
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = a;
    sb.push_back('{err: ee, data: ed});
    #1 check({tag, "/gnt"}, 32'(fetch_gnt), 32'd1);
    @(negedge clk);
    fetch_req  = 1'b0;
    fetch_addr = ~a;
    check({tag, "/lat1"}, 32'(instr_valid), 32'd0);
    @(negedge clk);
    check({tag, "/valid"}, 32'(instr_valid), 32'd1);
    pop_check(tag);
  endtask

  task automatic patch_write(input logic [IDX_W-1:0] idx, input logic en,
                             input logic [31:0] a, input logic [PATCH_W-1:0] v);
    @(negedge clk);
    patch_we   = 1'b1;
    patch_idx  = idx;
    patch_en   = en;
    patch_addr = a;
    patch_val  = v;
    @(negedge clk);
    patch_we   = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    fetch_req   = 1'b0;
    fetch_addr  = '0;
    instr_ready = 1'b1;
    patch_we    = 1'b0;
    patch_idx   = '0;
    patch_en    = 1'b0;
    patch_addr  = '0;
    patch_val   = '0;

    repeat (2) @(negedge clk);
    check("rst/valid", 32'(instr_valid), 32'd0);
    check("rst/data", instr_data, 32'h0);
    check("rst/err", 32'(instr_err), 32'd0);
    check("rst/gnt", 32'(fetch_gnt), 32'd1);
    rst_n = 1'b1;

    // Plain ROM reads and address boundaries
    fetch("rom3",     32'h0000_000C, 32'h2001_00A5, 1'b0);
    fetch("rom4",     32'h0000_0010, 32'h2001_00A6, 1'b0);
    fetch("rom0",     32'h0000_0000, 32'h2001_00A2, 1'b0);
    fetch("rom_last", 32'h0000_007C, 32'h2001_00C1, 1'b0);
    fetch("misalign", 32'h0000_000E, 32'h0, 1'b1);
    fetch("range",    32'h0000_0080, 32'h0, 1'b1);
    fetch("range_hi", 32'h8000_000C, 32'h0, 1'b1);

    // Patch substitution
    patch_write(2'd0, 1'b1, 32'h0000_000C, 4'h7);
    fetch("p_slot0", 32'h0000_000C, PATCH_ON ? 32'h2001_00A7 : 32'h2001_00A5, 1'b0);
    fetch("p_other", 32'h0000_0010, 32'h2001_00A6, 1'b0);
    patch_write(2'd0, 1'b0, 32'h0000_000C, 4'h7);
    patch_write(2'd1, 1'b1, 32'h0000_000C, 4'h3);
    patch_write(2'd2, 1'b1, 32'h0000_000C, 4'h9);
    fetch("p_lowest", 32'h0000_000C, PATCH_ON ? 32'h2001_00A3 : 32'h2001_00A5, 1'b0);
    patch_write(2'd3, 1'b1, 32'h0000_0010, 4'hF);
    fetch("p_oor", 32'h0000_0010, 32'h2001_00A6, 1'b0);
    patch_write(2'd0, 1'b1, 32'h0000_000E, 4'hF);
    fetch("p_err", 32'h0000_000E, 32'h0, 1'b1);

    // Patch written while the fetch is in READ applies only to later fetches
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = 32'h0000_0014;
    sb.push_back('{err: 1'b0, data: 32'h2001_00A7});
    @(negedge clk);
    fetch_req  = 1'b0;
    patch_we   = 1'b1;
    patch_idx  = 2'd0;
    patch_en   = 1'b1;
    patch_addr = 32'h0000_0014;
    patch_val  = 4'h1;
    @(negedge clk);
    patch_we = 1'b0;
    check("p_inread/valid", 32'(instr_valid), 32'd1);
    pop_check("p_inread");
    fetch("p_after", 32'h0000_0014, PATCH_ON ? 32'h2001_00A1 : 32'h2001_00A7, 1'b0);

    // Back-pressure: output stays put while instr_ready is low
    @(negedge clk);
    fetch_req   = 1'b1;
    fetch_addr  = 32'h0000_0000;
    instr_ready = 1'b0;
    sb.push_back('{err: 1'b0, data: 32'h2001_00A2});
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    check("hold/valid", 32'(instr_valid), 32'd1);
    pop_check("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_stall/valid", 32'(instr_valid), 32'd1);
      check("hold_stall/data", instr_data, 32'h2001_00A2);
      check("hold_stall/gnt", 32'(fetch_gnt), 32'd0);
    end
    instr_ready = 1'b1;
    fetch_req   = 1'b1;
    fetch_addr  = 32'h0000_0004;
    sb.push_back('{err: 1'b0, data: 32'h2001_00A3});
    #1 check("hold_next/gnt", 32'(fetch_gnt), 32'd1);
    @(negedge clk);
    fetch_req = 1'b0;
    check("hold_next/drop", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("hold_next/valid", 32'(instr_valid), 32'd1);
    pop_check("hold_next");

    // Reset during READ abandons the fetch and clears the patch table
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = 32'h0000_000C;
    @(negedge clk);
    fetch_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst/valid", 32'(instr_valid), 32'd0);
    check("midrst/data", instr_data, 32'h0);
    check("midrst/err", 32'(instr_err), 32'd0);
    check("midrst/gnt", 32'(fetch_gnt), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst/novalid", 32'(instr_valid), 32'd0);
    end
    fetch("post_rst", 32'h0000_000C, 32'h2001_00A5, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
